// File: rtl/ctrl_pkg.sv
// Shared types and decode constants for the addi/bne control sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        TRAP
    } state_e;

    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_BNE  = 7'b1100011;
    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic       ALU_ADD  = 1'b0;
    localparam logic       ALU_BNE  = 1'b1;

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extractor: I-type (addi) or B-type (bne), sign-extended.
module imm_ext #(
    parameter int unsigned Data_Width = 32
) (
    input  logic [Data_Width-1:0] instr,
    input  logic                  is_b,
    output logic [Data_Width-1:0] imm
);

    // Opcode, funct3 and rs1 fields never contribute to either immediate format.
    logic unused_bits;
    assign unused_bits = ^{instr[19:12], instr[6:0]};

    always_comb begin
        imm = '0;
        if (is_b) begin
            imm = {{(Data_Width-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
        end else begin
            imm = {{(Data_Width-12){instr[31]}}, instr[31:20]};
        end
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the addi/bne ALU datapath.
// Define ALU_CTRL_PERF_CNT_EN to build the retired/taken performance counters.
module alu_ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned         PC_WIDTH      = 32,
    parameter int unsigned         Data_Width    = 32,
    parameter int unsigned         Address_Width = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    input  logic                     imem_ack,
    input  logic [Data_Width-1:0]    instr,
    output logic [PC_WIDTH-1:0]      pc,
    input  logic                     eq,
    output logic                     ALU_ctrl,
    output logic                     ALUsrc,
    output logic [Data_Width-1:0]    ImmOp,
    output logic [Address_Width-1:0] rs1,
    output logic [Address_Width-1:0] rs2,
    output logic [Address_Width-1:0] rd,
    output logic                     RegWrite,
    output logic                     illegal,
    output logic [31:0]              retired_cnt,
    output logic [31:0]              taken_cnt
);

    state_e                state_q;
    logic [Data_Width-1:0] ir_q;
    logic                  taken_q;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  is_addi;
    logic                  is_bne;
    logic [Data_Width-1:0] imm;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign is_addi = (opcode == OPC_ADDI) && (funct3 == F3_ADDI);
    assign is_bne  = (opcode == OPC_BNE) && (funct3 == F3_BNE);

    imm_ext #(
        .Data_Width(Data_Width)
    ) u_imm_ext (
        .instr(ir_q),
        .is_b (is_bne),
        .imm  (imm)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc       <= RESET_PC;
            ir_q     <= '0;
            taken_q  <= 1'b0;
            imem_req <= 1'b0;
            RegWrite <= 1'b0;
            illegal  <= 1'b0;
            ALU_ctrl <= ALU_ADD;
            ALUsrc   <= 1'b0;
            ImmOp    <= '0;
            rs1      <= '0;
            rs2      <= '0;
            rd       <= '0;
        end else begin
            RegWrite <= 1'b0;
            unique case (state_q)
                FETCH: begin
                    // An ack only counts once the request is actually visible.
                    if (imem_req && imem_ack) begin
                        ir_q     <= instr;
                        imem_req <= 1'b0;
                        state_q  <= DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    rs1 <= ir_q[19:15];
                    rs2 <= ir_q[24:20];
                    rd  <= ir_q[11:7];
                    if (is_addi || is_bne) begin
                        ALU_ctrl <= is_bne ? ALU_BNE : ALU_ADD;
                        ALUsrc   <= is_addi;
                        ImmOp    <= imm;
                        state_q  <= EXECUTE;
                    end else begin
                        illegal <= 1'b1;
                        state_q <= TRAP;
                    end
                end
                EXECUTE: begin
                    taken_q  <= ~eq;
                    RegWrite <= (ALU_ctrl == ALU_ADD);
                    state_q  <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (ALU_ctrl == ALU_BNE && taken_q) begin
                        pc <= pc + PC_WIDTH'(ImmOp);
                    end else begin
                        pc <= pc + PC_WIDTH'(4);
                    end
                    // Raise the next request immediately so an instant ack costs no bubble.
                    imem_req <= 1'b1;
                    state_q  <= FETCH;
                end
                TRAP: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                    state_q  <= TRAP;
                end
            endcase
        end
    end

`ifdef ALU_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_cnt <= '0;
            taken_cnt   <= '0;
        end else if (state_q == WRITEBACK) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (ALU_ctrl == ALU_BNE && taken_q) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end
`else
    assign retired_cnt = '0;
    assign taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer: reset, addi, bne, stalls, trap, wrap and counters.
module tb_alu_ctrl_sequencer;

    localparam logic [31:0] ADDI5   = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADDIM1  = 32'hFFF10193;  // addi x3,x2,-1
    localparam logic [31:0] BNEM8   = 32'hFE209CE3;  // bne x1,x2,-8
    localparam logic [31:0] ILL_ADD = 32'h00000033;  // add x0,x0,x0

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic        eq = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_req;
    logic [31:0] pc;
    logic        ALU_ctrl;
    logic        ALUsrc;
    logic [31:0] ImmOp;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        illegal;
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;

    int total = 0;
    int bad = 0;

    alu_ctrl_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .pc         (pc),
        .eq         (eq),
        .ALU_ctrl   (ALU_ctrl),
        .ALUsrc     (ALUsrc),
        .ImmOp      (ImmOp),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .retired_cnt(retired_cnt),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assumes a FETCH cycle with imem_req already high; ends in the next FETCH cycle.
    task automatic run_instr(input logic [31:0] w, input int stall, input logic e);
        eq = e;
        imem_ack = 1'b0;
        repeat (stall) step();
        imem_ack = 1'b1;
        instr = w;
        step();
        imem_ack = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        imem_ack = 1'b1;
        instr = ADDI5;
        step();
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b want=0", RegWrite); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
        total++; if ({ALU_ctrl, ALUsrc} !== 2'b00) begin bad++; $display("FAIL reset_ctrl got=%b%b want=00", ALU_ctrl, ALUsrc); end
        total++; if ({ImmOp, rs1, rs2, rd} !== 47'h0) begin bad++; $display("FAIL reset_fields got=%h/%h/%h/%h want=0", ImmOp, rs1, rs2, rd); end
        total++; if ({retired_cnt, taken_cnt} !== 64'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h want=0", retired_cnt, taken_cnt); end
        rst = 1'b1;
        imem_ack = 1'b0;
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req got=%b want=1", imem_req); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL release_pc got=%h want=%h", pc, 32'h0); end
    endtask

    task automatic test_addi();
        imem_ack = 1'b1;
        instr = ADDI5;
        step();
        imem_ack = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL addi_req_drop got=%b want=0", imem_req); end
        step();
        total++; if (ALU_ctrl !== 1'b0) begin bad++; $display("FAIL addi_aluctrl got=%b want=0", ALU_ctrl); end
        total++; if (ALUsrc !== 1'b1) begin bad++; $display("FAIL addi_alusrc got=%b want=1", ALUsrc); end
        total++; if (ImmOp !== 32'h5) begin bad++; $display("FAIL addi_imm got=%h want=%h", ImmOp, 32'h5); end
        total++; if (rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d want=1", rd); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL addi_rw_early got=%b want=0", RegWrite); end
        step();
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL addi_rw_pulse got=%b want=1", RegWrite); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL addi_pc_hold got=%h want=%h", pc, 32'h0); end
        step();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL addi_rw_end got=%b want=0", RegWrite); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL addi_pc got=%h want=%h", pc, 32'h4); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL addi_next_req got=%b want=1", imem_req); end
    endtask

    task automatic test_reset_mid_fetch();
        rst = 1'b0;
        imem_ack = 1'b1;
        instr = ADDI5;
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL midrst_pc got=%h want=%h", pc, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b want=0", imem_req); end
        total++; if (ImmOp !== 32'h0) begin bad++; $display("FAIL midrst_imm got=%h want=%h", ImmOp, 32'h0); end
        rst = 1'b1;
        imem_ack = 1'b0;
        step();
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL midrst_refetch got=%b want=1", imem_req); end
        total++; if (ALUsrc !== 1'b0) begin bad++; $display("FAIL midrst_nodecode got=%b want=0", ALUsrc); end
    endtask

    task automatic test_bne();
        int rw;
        repeat (4) run_instr(ADDI5, 0, 1'b0);
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL bne_setup_pc got=%h want=%h", pc, 32'h10); end
        // Taken: eq=0 during EXECUTE.
        rw = 0;
        eq = 1'b0;
        imem_ack = 1'b1;
        instr = BNEM8;
        step();
        imem_ack = 1'b0;
        rw += int'(RegWrite);
        step();
        rw += int'(RegWrite);
        total++; if (ALU_ctrl !== 1'b1) begin bad++; $display("FAIL bne_aluctrl got=%b want=1", ALU_ctrl); end
        total++; if (ALUsrc !== 1'b0) begin bad++; $display("FAIL bne_alusrc got=%b want=0", ALUsrc); end
        total++; if (ImmOp !== 32'hFFFFFFF8) begin bad++; $display("FAIL bne_imm got=%h want=%h", ImmOp, 32'hFFFFFFF8); end
        total++; if ({rs1, rs2} !== {5'd1, 5'd2}) begin bad++; $display("FAIL bne_rs got=%0d,%0d want=1,2", rs1, rs2); end
        step();
        rw += int'(RegWrite);
        step();
        rw += int'(RegWrite);
        total++; if (pc !== 32'h8) begin bad++; $display("FAIL bne_taken_pc got=%h want=%h", pc, 32'h8); end
        total++; if (rw !== 0) begin bad++; $display("FAIL bne_taken_rw got=%0d want=0", rw); end
        // Not taken: eq=1.
        repeat (2) run_instr(ADDI5, 0, 1'b0);
        rw = 0;
        eq = 1'b1;
        imem_ack = 1'b1;
        instr = BNEM8;
        step();
        imem_ack = 1'b0;
        repeat (3) begin
            rw += int'(RegWrite);
            step();
        end
        rw += int'(RegWrite);
        total++; if (pc !== 32'h14) begin bad++; $display("FAIL bne_nt_pc got=%h want=%h", pc, 32'h14); end
        total++; if (rw !== 0) begin bad++; $display("FAIL bne_nt_rw got=%0d want=0", rw); end
    endtask

    task automatic test_stall();
        int reqcnt;
        int n;
        reqcnt = 0;
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            reqcnt += int'(imem_req);
            step();
            total++; if (ImmOp !== 32'hFFFFFFF8 || ALU_ctrl !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b want=%h/1", ImmOp, ALU_ctrl, 32'hFFFFFFF8); end
        end
        reqcnt += int'(imem_req);
        imem_ack = 1'b1;
        instr = ADDIM1;
        step();
        imem_ack = 1'b0;
        n = 4;
        while (pc === 32'h14 && n < 20) begin
            step();
            n++;
        end
        total++; if (reqcnt !== 4) begin bad++; $display("FAIL stall_req_cycles got=%0d want=4", reqcnt); end
        total++; if (n !== 7) begin bad++; $display("FAIL stall_latency got=%0d want=7", n); end
        total++; if (pc !== 32'h18) begin bad++; $display("FAIL stall_pc got=%h want=%h", pc, 32'h18); end
        total++; if (ImmOp !== 32'hFFFFFFFF) begin bad++; $display("FAIL stall_imm got=%h want=%h", ImmOp, 32'hFFFFFFFF); end
        total++; if ({rs1, rd, ALUsrc} !== {5'd2, 5'd3, 1'b1}) begin bad++; $display("FAIL stall_fields got=%0d,%0d,%b want=2,3,1", rs1, rd, ALUsrc); end
    endtask

    task automatic test_illegal();
        imem_ack = 1'b1;
        instr = ILL_ADD;
        step();
        imem_ack = 1'b0;
        step();
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b want=1", illegal); end
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (imem_req !== 1'b0 || RegWrite !== 1'b0) begin bad++; $display("FAIL trap_quiet cyc=%0d got=%b/%b want=0/0", i, imem_req, RegWrite); end
            total++; if (pc !== 32'h18) begin bad++; $display("FAIL trap_pc cyc=%0d got=%h want=%h", i, pc, 32'h18); end
        end
        do_reset();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b want=0", illegal); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL ill_reset_pc got=%h want=%h", pc, 32'h0); end
    endtask

    task automatic test_wrap();
        run_instr(BNEM8, 0, 1'b0);
        total++; if (pc !== 32'hFFFFFFF8) begin bad++; $display("FAIL wrap_back got=%h want=%h", pc, 32'hFFFFFFF8); end
        repeat (2) run_instr(ADDI5, 0, 1'b0);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_fwd got=%h want=%h", pc, 32'h0); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_ret;
        logic [31:0] exp_tak;
`ifdef ALU_CTRL_PERF_CNT_EN
        exp_ret = 32'd3;
        exp_tak = 32'd1;
`else
        exp_ret = 32'd0;
        exp_tak = 32'd0;
`endif
        do_reset();
        total++; if ({retired_cnt, taken_cnt} !== 64'h0) begin bad++; $display("FAIL perf_clear got=%h/%h want=0", retired_cnt, taken_cnt); end
        run_instr(ADDI5, 0, 1'b0);
        run_instr(BNEM8, 0, 1'b0);
        run_instr(BNEM8, 1, 1'b1);
        total++; if (retired_cnt !== exp_ret) begin bad++; $display("FAIL perf_retired got=%0d want=%0d", retired_cnt, exp_ret); end
        total++; if (taken_cnt !== exp_tak) begin bad++; $display("FAIL perf_taken got=%0d want=%0d", taken_cnt, exp_tak); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL perf_pc got=%h want=%h", pc, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_reset_mid_fetch();
        test_bne();
        test_stall();
        test_illegal();
        test_wrap();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Multi-cycle control sequencer that drives the reduced RISC-V ALU.
- Fetches instructions over a req/ack handshake and decodes addi/bne.
- Drives ALU_ctrl, the operand-select signals, the register addresses and the immediate.
- Samples the ALU eq flag to resolve bne and update the PC.
- Sits between instruction memory and the register-file/ALU datapath.

Parameters:
PC_WIDTH, 32, program counter width in bits
Data_Width, 32, instruction and immediate width
Address_Width, 5, register address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state changes on the rising edge
rst  input  1  synchronous active-low reset; sampled on the clk rising edge, asserted when 0
imem_req  output  1  instruction fetch request
imem_ack  input  1  instruction memory has valid data on instr this cycle
instr  input  Data_Width  fetched instruction word
pc  output  PC_WIDTH  current program counter and fetch address
eq  input  1  ALU flag; 0 means op1!=op2
ALU_ctrl  output  1  0 = add (addi), 1 = compare (bne)
ALUsrc  output  1  1 = op2 comes from ImmOp, 0 = op2 comes from register rs2
ImmOp  output  Data_Width  sign-extended immediate
rs1  output  Address_Width  source register 1
rs2  output  Address_Width  source register 2
rd  output  Address_Width  destination register
RegWrite  output  1  register write enable, single-cycle pulse
illegal  output  1  sticky flag: unsupported instruction decoded
retired_cnt  output  32  retired instruction count (optional feature)
taken_cnt  output  32  taken branch count (optional feature)

Behaviour:
Reset (rst==0 at a clock edge):
- state=FETCH, pc=RESET_PC.
- imem_req, RegWrite, illegal, ALU_ctrl, ALUsrc = 0.
- ImmOp, rs1, rs2, rd, instruction register, counters = 0.
- Reset overrides every state, including mid-handshake. An ack arriving in the reset cycle is ignored.

States are FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.

FETCH:
- imem_req=1 held until the cycle in which imem_ack=1.
- On ack: latch instr into the instruction register, go to DECODE; imem_req drops the next cycle.
- No timeout; the sequencer waits indefinitely.

DECODE (1 cycle):
- rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7].
- addi (opcode 0010011, funct3 000):
  - ALU_ctrl=0, ALUsrc=1.
  - ImmOp = sign-extended IR[31:20].
- bne (opcode 1100011, funct3 001):
  - ALU_ctrl=1, ALUsrc=0.
  - ImmOp = sign-extended {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
- Any other encoding: illegal=1, go to TRAP.

EXECUTE (1 cycle):
- Outputs are held so the ALU settles.
- bne: eq is sampled at the end of this cycle into taken = ~eq.

WRITEBACK (1 cycle):
- addi:
  - RegWrite=1 for exactly this cycle.
  - Writes with rd=0 are still pulsed; x0 protection belongs to the register file.
  - pc += 4.
- bne: pc = taken ? pc+ImmOp[PC_WIDTH-1:0] : pc+4.
- Go to FETCH.

PC arithmetic:
- Modulo 2^PC_WIDTH; wrap-around is silent.
- Negative offsets via two's complement.

Latency:
- 4 cycles per instruction when imem_ack arrives in the first FETCH cycle.
- Each stall cycle adds one.

TRAP:
- Terminal state. imem_req=0, RegWrite=0, pc frozen.
- Exit only via reset.

ALU_ctrl/ALUsrc/ImmOp/rs*/rd:
- Registered; they change only on the DECODE edge.

Optional Feature:
Macro ALU_CTRL_PERF_CNT_EN.
- Defined:
  - retired_cnt increments in every WRITEBACK cycle.
  - taken_cnt increments in WRITEBACK when a bne is taken.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum type (FETCH..TRAP)
  - OPC_ADDI=7'b0010011, OPC_BNE=7'b1100011
  - F3_ADDI=3'b000, F3_BNE=3'b001
  - ALU_ADD=1'b0, ALU_BNE=1'b1
- One combinational sub-module, imm_ext: takes the instruction word and an I/B type select, outputs the sign-extended immediate.

Test Plan:
1. Reset then release: pc=0, imem_req=1 the first cycle after release. Hold rst low mid-FETCH -> pc returns to 0 and imem_req=0.
2. instr=addi x1,x0,5 (0x00500093), ack immediate -> ALU_ctrl=0, ALUsrc=1, ImmOp=5, rd=1. RegWrite pulses once, 4 cycles after ack request start. pc=4.
3. bne x1,x2,-8 at pc=0x10 (0xFE209CE3), eq=0 in EXECUTE -> ImmOp=0xFFFFFFF8, pc=0x08. Repeat with eq=1 -> pc=0x14, RegWrite never asserted.
4. imem_ack delayed 3 cycles -> imem_req held high for 4 cycles, instruction retires in 7 cycles, outputs unchanged during the stall.
5. instr=0x00000033 (add, unsupported) -> illegal=1, state TRAP, imem_req stays 0 for 20 cycles, pc frozen. Reset clears illegal.
6. With ALU_CTRL_PERF_CNT_EN: run addi, bne taken, bne not taken -> retired_cnt=3, taken_cnt=1. Without the macro, both read 0.
